// File: rtl/id_queue_stage.sv
// RV32I decode stage with a DEPTH-entry micro-op FIFO in front of rename/dispatch.
// Decode is combinational on in_inst; only FIFO storage drives the out_* ports.
module id_queue_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [31:0]                      in_inst,
    input  logic [XLEN-1:0]                  in_pc,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [XLEN-1:0]                  out_pc,
    output logic [4:0]                       out_rs1,
    output logic [4:0]                       out_rs2,
    output logic [4:0]                       out_rd,
    output logic                             out_rd_we,
    output logic [XLEN-1:0]                  out_imm,
    output logic                             out_use_imm,
    output logic [3:0]                       out_alu_op,
    output logic                             out_is_branch,
    output logic                             out_is_jal,
    output logic                             out_is_jalr,
    output logic                             out_is_auipc,
    output logic [2:0]                       out_br_type,
    output logic                             out_is_load,
    output logic                             out_is_store,
    output logic [2:0]                       out_mem_size,
    output logic                             out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic [3:0]      alu_op;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            is_auipc;
        logic [2:0]      br_type;
        logic            is_load;
        logic            is_store;
        logic [2:0]      mem_size;
        logic            illegal;
    } uop_t;

    uop_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    uop_t             dec;
    uop_t             head;
    logic             push;
    logic             pop;
    logic             ill;
    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

    // Operand fields a format does not read stay 0 so rename sees no false dependency.
    always_comb begin
        opcode = in_inst[6:0];
        f3     = in_inst[14:12];
        f7     = in_inst[31:25];
        imm_i  = XLEN'($signed(in_inst[31:20]));
        imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
        imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
        imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
        ill    = 1'b0;
        dec    = '0;
        dec.pc = in_pc;
        case (opcode)
            7'b0110011: begin
                dec.rs1   = in_inst[19:15];
                dec.rs2   = in_inst[24:20];
                dec.rd    = in_inst[11:7];
                dec.rd_we = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  dec.alu_op = ALU_ADD;
                            3'b001:  dec.alu_op = ALU_SLL;
                            3'b010:  dec.alu_op = ALU_SLT;
                            3'b011:  dec.alu_op = ALU_SLTU;
                            3'b100:  dec.alu_op = ALU_XOR;
                            3'b101:  dec.alu_op = ALU_SRL;
                            3'b110:  dec.alu_op = ALU_OR;
                            default: dec.alu_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
                        else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
                        else                   ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.rs1     = in_inst[19:15];
                dec.rd      = in_inst[11:7];
                dec.rd_we   = 1'b1;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                case (f3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b001: begin
                        if (f7 == 7'b0000000) dec.alu_op = ALU_SLL;
                        else                  ill = 1'b1;
                    end
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b101: begin
                        if (in_inst[29:25] != 5'd0) ill = 1'b1;
                        else dec.alu_op = in_inst[30] ? ALU_SRA : ALU_SRL;
                    end
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            7'b0110111: begin
                dec.rd      = in_inst[11:7];
                dec.rd_we   = 1'b1;
                dec.imm     = imm_u;
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_PASSB;
            end
            7'b0010111: begin
                dec.rd       = in_inst[11:7];
                dec.rd_we    = 1'b1;
                dec.imm      = imm_u;
                dec.use_imm  = 1'b1;
                dec.is_auipc = 1'b1;
            end
            7'b1101111: begin
                dec.rd     = in_inst[11:7];
                dec.rd_we  = 1'b1;
                dec.imm    = imm_j;
                dec.is_jal = 1'b1;
            end
            7'b1100111: begin
                dec.rs1     = in_inst[19:15];
                dec.rd      = in_inst[11:7];
                dec.rd_we   = 1'b1;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.is_jalr = 1'b1;
                ill         = (f3 != 3'b000);
            end
            7'b1100011: begin
                dec.rs1       = in_inst[19:15];
                dec.rs2       = in_inst[24:20];
                dec.imm       = imm_b;
                dec.is_branch = 1'b1;
                dec.br_type   = f3;
                ill           = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0000011: begin
                dec.rs1      = in_inst[19:15];
                dec.rd       = in_inst[11:7];
                dec.rd_we    = 1'b1;
                dec.imm      = imm_i;
                dec.use_imm  = 1'b1;
                dec.is_load  = 1'b1;
                dec.mem_size = f3;
                ill          = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin
                dec.rs1      = in_inst[19:15];
                dec.rs2      = in_inst[24:20];
                dec.imm      = imm_s;
                dec.use_imm  = 1'b1;
                dec.is_store = 1'b1;
                dec.mem_size = f3;
                ill          = (f3 > 3'b010);
            end
            default: ill = 1'b1;
        endcase
        dec.rd_we = dec.rd_we && (dec.rd != 5'd0);
        if (ill) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
        if ($isunknown(in_inst)) begin
            dec    = '0;
            dec.pc = in_pc;
        end
    end

    // Queue control; flush wins over a same-edge push or pop.
    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) mem_q[wr_ptr_q] <= dec;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign in_ready      = (count_q < CNT_W'(DEPTH));
    assign out_valid     = (count_q != '0);
    assign occupancy     = count_q;
    assign out_pc        = head.pc;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_rd        = head.rd;
    assign out_rd_we     = head.rd_we;
    assign out_imm       = head.imm;
    assign out_use_imm   = head.use_imm;
    assign out_alu_op    = head.alu_op;
    assign out_is_branch = head.is_branch;
    assign out_is_jal    = head.is_jal;
    assign out_is_jalr   = head.is_jalr;
    assign out_is_auipc  = head.is_auipc;
    assign out_br_type   = head.br_type;
    assign out_is_load   = head.is_load;
    assign out_is_store  = head.is_store;
    assign out_mem_size  = head.mem_size;
    assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_id_queue_stage.sv
// Scoreboard bench for id_queue_stage: directed vectors queue hand-computed micro-ops,
// a negedge monitor checks the head, occupancy and handshakes against the queue.
module tb_id_queue_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] imm;
        logic        use_imm;
        logic [3:0]  alu_op;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_auipc;
        logic [2:0]  br_type;
        logic        is_load;
        logic        is_store;
        logic [2:0]  mem_size;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rd_we, out_use_imm, out_is_branch, out_is_jal, out_is_jalr, out_is_auipc;
    logic        out_is_load, out_is_store, out_illegal;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_br_type, out_mem_size, occupancy;

    int   checks = 0;
    int   errors = 0;
    exp_t cur_exp;
    exp_t sb[$];
    exp_t act;

    always #5 clk = ~clk;

    id_queue_stage #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_alu_op(out_alu_op), .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
        .out_is_jalr(out_is_jalr), .out_is_auipc(out_is_auipc), .out_br_type(out_br_type),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_mem_size(out_mem_size),
        .out_illegal(out_illegal), .occupancy(occupancy)
    );

    assign act = '{out_pc, out_rs1, out_rs2, out_rd, out_rd_we, out_imm, out_use_imm, out_alu_op,
                   out_is_branch, out_is_jal, out_is_jalr, out_is_auipc, out_br_type,
                   out_is_load, out_is_store, out_mem_size, out_illegal};

    // cls = {branch, jal, jalr, auipc, load, store}
    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                                input logic we, input logic [31:0] imm, input logic ui,
                                input logic [3:0] alu, input logic [5:0] cls,
                                input logic [2:0] br, msz, input logic ill);
        exp_t e;
        e = '{pc, rs1, rs2, rd, we, imm, ui, alu, cls[5], cls[4], cls[3], cls[2], br,
              cls[1], cls[0], msz, ill};
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] r);
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, a, r);
        end
    endtask

    // Monitor: compare the pre-edge DUT state with the model, then apply the edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            int n;
            n = sb.size();
            chk("occupancy", 128'(occupancy), 128'(n));
            chk("in_ready", 128'(in_ready), 128'(n < 4));
            chk("out_valid", 128'(out_valid), 128'(n != 0));
            if (n != 0 && out_valid) chk("head", 128'(act), 128'(sb[0]));
            if (flush) sb.delete();
            else begin
                if (n != 0 && out_ready) void'(sb.pop_front());
                if (in_valid && n < 4) sb.push_back(cur_exp);
            end
        end
    end

    task automatic drive1(input logic [31:0] inst, pc, input exp_t e);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; cur_exp = e;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic offer(input logic [31:0] inst, pc, input exp_t e);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_inst = inst; in_pc = pc; cur_exp = e;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk); #1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL offer_timeout: pc %h not accepted within 20 cycles", pc);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_SUB   = 32'h4020_81B3;
    localparam logic [31:0] I_LW    = 32'hFFC1_2283;
    localparam logic [31:0] I_BEQ   = 32'h0000_0463;
    localparam logic [31:0] I_BAD   = 32'h0000_007F;
    localparam logic [31:0] I_MUL   = 32'h0220_81B3;
    localparam logic [31:0] I_LUI   = 32'h1234_53B7;
    localparam logic [31:0] I_AUIPC = 32'hFFFF_F117;
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;
    localparam logic [31:0] I_SW    = 32'hFE51_2C23;
    localparam logic [31:0] I_JALR  = 32'h0000_8067;
    localparam logic [31:0] I_SRAI  = 32'h4030_D213;

    initial begin
        exp_t e_addi, e_jalr;
        logic [31:0] xv;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = I_ADDI; in_pc = 32'h100; cur_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_fields", 128'(act), 128'(0));
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;

        e_addi = mk(32'h100, 0, 0, 1, 1, 32'd5, 1, 4'd0, 6'b000000, 3'd0, 3'd0, 0);
        offer(I_ADDI, 32'h100, e_addi);
        offer(I_SUB,  32'h104, mk(32'h104, 1, 2, 3, 1, 32'd0, 0, 4'd1, 6'b000000, 3'd0, 3'd0, 0));
        offer(I_LW,   32'h108, mk(32'h108, 2, 0, 5, 1, 32'hFFFF_FFFC, 1, 4'd0, 6'b000010, 3'd0, 3'd2, 0));
        offer(I_BEQ,  32'h10C, mk(32'h10C, 0, 0, 0, 0, 32'd8, 0, 4'd0, 6'b100000, 3'd0, 3'd0, 0));
        offer(I_BAD,  32'h110, mk(32'h110, 0, 0, 0, 0, 32'd0, 0, 4'd0, 6'b000000, 3'd0, 3'd0, 1));
        offer(I_MUL,  32'h114, mk(32'h114, 0, 0, 0, 0, 32'd0, 0, 4'd0, 6'b000000, 3'd0, 3'd0, 1));
        idle(3);

        // Fill with dispatch stalled, pointers start mid-array so the fill wraps.
        out_ready = 1'b0;
        drive1(I_LUI,   32'h120, mk(32'h120, 0, 0, 7, 1, 32'h1234_5000, 1, 4'd10, 6'b000000, 3'd0, 3'd0, 0));
        drive1(I_AUIPC, 32'h124, mk(32'h124, 0, 0, 2, 1, 32'hFFFF_F000, 1, 4'd0, 6'b000100, 3'd0, 3'd0, 0));
        drive1(I_JAL,   32'h128, mk(32'h128, 0, 0, 1, 1, 32'd16, 0, 4'd0, 6'b010000, 3'd0, 3'd0, 0));
        drive1(I_SW,    32'h12C, mk(32'h12C, 2, 5, 0, 0, 32'hFFFF_FFF8, 1, 4'd0, 6'b000001, 3'd0, 3'd2, 0));
        e_jalr = mk(32'h130, 1, 0, 0, 0, 32'd0, 1, 4'd0, 6'b001000, 3'd0, 3'd0, 0);
        in_valid = 1'b1; in_inst = I_JALR; in_pc = 32'h130; cur_exp = e_jalr;
        @(negedge clk);
        chk("full_occupancy", 128'(occupancy), 128'(4));
        chk("full_in_ready", 128'(in_ready), 128'(0));
        chk("full_head_pc", 128'(out_pc), 128'(32'h120));
        @(posedge clk); #1;
        out_ready = 1'b1;
        offer(I_JALR, 32'h130, e_jalr);
        offer(I_SRAI, 32'h134, mk(32'h134, 1, 0, 4, 1, 32'h0000_0403, 1, 4'd7, 6'b000000, 3'd0, 3'd0, 0));
        idle(6);

        // Flush a full queue with a simultaneous offer, then flush an empty one.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e_addi.pc = 32'h200 + 32'(4 * i);
            drive1(I_ADDI, e_addi.pc, e_addi);
        end
        flush = 1'b1; in_valid = 1'b1; in_inst = I_SUB; in_pc = 32'h210; cur_exp = '0;
        @(posedge clk); #1;
        chk("flush_occupancy", 128'(occupancy), 128'(0));
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        chk("flush_push_dropped", 128'(occupancy), 128'(0));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(1);

        xv = 'x;
        if ($isunknown(xv))
            offer(xv, 32'h140, mk(32'h140, 0, 0, 0, 0, 32'd0, 0, 4'd0, 6'b000000, 3'd0, 3'd0, 0));
        else
            offer(32'h0, 32'h140, mk(32'h140, 0, 0, 0, 0, 32'd0, 0, 4'd0, 6'b000000, 3'd0, 3'd0, 1));
        e_addi.pc = 32'h144;
        offer(I_ADDI, 32'h144, e_addi);
        idle(4);

        // Reset in mid-operation discards buffered entries and zeroes storage.
        out_ready = 1'b0;
        drive1(I_LUI, 32'h300, mk(32'h300, 0, 0, 7, 1, 32'h1234_5000, 1, 4'd10, 6'b000000, 3'd0, 3'd0, 0));
        drive1(I_LW,  32'h304, mk(32'h304, 2, 0, 5, 1, 32'hFFFF_FFFC, 1, 4'd0, 6'b000010, 3'd0, 3'd2, 0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_occupancy", 128'(occupancy), 128'(0));
        chk("midrst_fields", 128'(act), 128'(0));
        rst_n = 1'b1; out_ready = 1'b1;
        idle(3);

        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_queue_stage.md
Name: id_queue_stage

Overview:
- Registered, parametrised successor to the combinational decode stage.
- Accepts fetched instructions over a valid/ready handshake and decodes the RV32I base integer set: all ALU reg/imm ops, LUI, AUIPC, JAL, JALR, all six branches, byte/half/word loads and stores.
- Flags illegal encodings.
- Buffers decoded micro-ops in a DEPTH-entry FIFO that feeds rename/dispatch of the out-of-order backend, and supports a single-cycle flush on redirect.

Parameters:
XLEN, 32, datapath width of pc and imm; legal values 32 or 64; instruction width is always 32.
DEPTH, 4, decoded-entry FIFO depth; power of two, >= 2.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active low
flush  input  1  discard all buffered entries (branch redirect)
in_valid  input  1  fetch offers an instruction
in_ready  output  1  stage can accept this cycle
in_inst  input  32  raw instruction
in_pc  input  XLEN  instruction address
out_valid  output  1  head entry valid
out_ready  input  1  dispatch consumes head
out_pc  output  XLEN  pc of head entry
out_rs1, out_rs2, out_rd  output  5 each  register indices
out_rd_we  output  1  instruction writes rd (forced 0 when rd==0)
out_imm  output  XLEN  sign-extended immediate
out_use_imm  output  1  ALU operand B is imm
out_alu_op  output  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
out_is_branch, out_is_jal, out_is_jalr, out_is_auipc  output  1 each  control class
out_br_type  output  3  funct3 of branch (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
out_is_load, out_is_store  output  1 each  memory class
out_mem_size  output  3  funct3 of load/store
out_illegal  output  1  illegal encoding
occupancy  output  clog2(DEPTH+1)  entries held

Behaviour:
- Interface: clock is clk; reset is rst_n, synchronous, active low.
- Reset, sampled on the rising edge with rst_n=0:
  - read/write pointers and count go to 0; out_valid=0; occupancy=0.
  - All storage is zeroed, so every out_* field reads 0. This also holds mid-operation, discarding any entries.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < DEPTH). There is no full-queue bypass: when full, in_ready=0 even if out_ready=1.
  - out_valid = (count != 0). Head fields are held stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge N is visible at the outputs after edge N (one cycle). No combinational path from in_* to out_*.
- Count update:
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Flush: count and pointers go to 0 on the edge. flush has priority over a simultaneous push or pop (the pushed instruction is dropped). in_ready stays combinational on count.
- Decode (combinational on in_inst, registered into FIFO):
  - If in_inst has any X/Z bit, enqueue a NOP: all fields 0, illegal=0, pc kept.
  - OP (0110011): use_imm=0; rd_we=1.
    - funct7 0000000 maps funct3 to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
    - funct7 0100000 is valid only with funct3 000 (SUB) or 101 (SRA).
    - Any other funct7 is illegal.
  - OP-IMM (0010011): I-imm; use_imm=1.
    - funct3 000 is ADD; inst[30] is ignored.
    - SLLI requires funct7=0000000.
    - SRLI/SRAI select on inst[30] and require inst[29:25]=0; otherwise illegal.
  - LUI: imm = inst[31:12]<<12, sign-extended; alu_op=PASSB; use_imm=1.
  - AUIPC: same imm; is_auipc=1; alu_op=ADD.
  - JAL: J-imm; is_jal=1; rd_we=1.
  - JALR: I-imm; is_jalr=1; funct3 must be 000.
  - BRANCH: B-imm; rd_we=0; funct3 010 or 011 is illegal.
  - LOAD: I-imm; funct3 must be in {000,001,010,100,101}.
  - STORE: S-imm; rd_we=0; funct3 must be in {000,001,010}.
  - Any other opcode is illegal.
  - Illegal entries are still enqueued: illegal=1, pc kept, all other fields 0.
- Immediates are sign-extended from inst[31] to XLEN. Branch and JAL immediates have bit0=0.

Test Plan:
- Reset with rst_n=0 for 2 cycles while in_valid=1 -> out_valid=0, occupancy=0, all out fields 0, in_ready=1 after release.
- ADDI 0x00500093 at pc 0x100 -> next cycle out_valid=1, rd=1, rd_we=1, imm=5, use_imm=1, alu_op=0, pc=0x100; SUB 0x402081B3 -> alu_op=1, rs1=1, rs2=2, rd=3.
- LW 0xFFC12283 -> is_load=1, mem_size=010, rs1=2, rd=5, imm=0xFFFFFFFC; BEQ 0x00000463 -> is_branch=1, br_type=000, imm=8, rd_we=0.
- out_ready=0, push DEPTH=4 instructions -> occupancy=4, in_ready=0 on the 5th offer, head unchanged. Then out_ready=1 with in_valid=1 -> pops 4 entries in order, FIFO order preserved across pointer wrap.
- Full queue, flush=1 with in_valid=1 on the same edge -> occupancy=0, out_valid=0, pushed instruction dropped.
- Opcode 0x7F, and OP with funct7=0000001 -> out_illegal=1, rd_we=0; X-valued in_inst -> NOP entry with illegal=0.
